// File: rtl/ucsbece154b_writeback.sv
// Writeback stage: MEM/WB pipeline register, load extraction, result select,
// register-file write port, W-stage forwarding outputs and retired-instruction counter.
module ucsbece154b_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_m_i,
    input  logic        stall_w_i,
    input  logic        flush_w_i,
    input  logic [4:0]  rd_m_i,
    input  logic        regwrite_m_i,
    input  logic [1:0]  resultsrc_m_i,
    input  logic [2:0]  funct3_m_i,
    input  logic [31:0] aluresult_m_i,
    input  logic [31:0] readdata_m_i,
    input  logic [31:0] pcplus4_m_i,
    output logic [4:0]  a3_o,
    output logic [31:0] wd3_o,
    output logic        we3_o,
    output logic [31:0] result_w_o,
    output logic [4:0]  rd_w_o,
    output logic        regwrite_w_o,
    output logic        misaligned_o,
    output logic [63:0] instret_o
);

    logic        valid_w_q;
    logic [4:0]  rd_w_q;
    logic        regwrite_w_q;
    logic [1:0]  resultsrc_w_q;
    logic [2:0]  funct3_w_q;
    logic [31:0] alu_w_q;
    logic [31:0] rdata_w_q;
    logic [31:0] pc4_w_q;
    logic [63:0] instret_q;

    logic [1:0]  off;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] result;
    logic        is_load;
    logic        misaligned;

    // MEM/WB register: reset > flush > stall > capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_w_q     <= 1'b0;
            rd_w_q        <= 5'd0;
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= 2'b00;
            funct3_w_q    <= 3'b000;
            alu_w_q       <= 32'd0;
            rdata_w_q     <= 32'd0;
            pc4_w_q       <= 32'd0;
        end else if (flush_w_i) begin
            // Only validity matters for a squashed slot; other fields keep stale data.
            valid_w_q <= 1'b0;
        end else if (!stall_w_i) begin
            valid_w_q     <= valid_m_i;
            rd_w_q        <= rd_m_i;
            regwrite_w_q  <= regwrite_m_i;
            resultsrc_w_q <= resultsrc_m_i;
            funct3_w_q    <= funct3_m_i;
            alu_w_q       <= aluresult_m_i;
            rdata_w_q     <= readdata_m_i;
            pc4_w_q       <= pcplus4_m_i;
        end
    end

    // Retired-instruction counter; advances when a live W instruction leaves the stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= 64'd0;
        end else if (valid_w_q && !stall_w_i) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    // Load extraction (little-endian) and misalignment detection.
    always_comb begin
        off = alu_w_q[1:0];
        unique case (off)
            2'd0:    byte_sel = rdata_w_q[7:0];
            2'd1:    byte_sel = rdata_w_q[15:8];
            2'd2:    byte_sel = rdata_w_q[23:16];
            default: byte_sel = rdata_w_q[31:24];
        endcase
        half_sel = off[1] ? rdata_w_q[31:16] : rdata_w_q[15:0];
        unique case (funct3_w_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = rdata_w_q;
        endcase
        is_load    = valid_w_q && (resultsrc_w_q == 2'b01);
        misaligned = is_load &&
                     ((((funct3_w_q == 3'b001) || (funct3_w_q == 3'b101)) && off[0]) ||
                      ((funct3_w_q == 3'b010) && (off != 2'd0)));
    end

    // Result select and register-file port.
    always_comb begin
        unique case (resultsrc_w_q)
            2'b01:   result = load_data;
            2'b10:   result = pc4_w_q;
            default: result = alu_w_q; // 11 is reserved and behaves as ALU
        endcase
        a3_o         = rd_w_q;
        wd3_o        = result;
        result_w_o   = result;
        we3_o        = valid_w_q && regwrite_w_q && (rd_w_q != 5'd0) && !misaligned;
        regwrite_w_o = we3_o;
        rd_w_o       = valid_w_q ? rd_w_q : 5'd0;
        misaligned_o = misaligned;
        instret_o    = instret_q;
    end

endmodule

// File: tb/tb_ucsbece154b_writeback.sv
// Self-checking bench for the writeback stage: vector table plus directed sequences.
module tb_ucsbece154b_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m_i, stall_w_i, flush_w_i;
    logic [4:0]  rd_m_i;
    logic        regwrite_m_i;
    logic [1:0]  resultsrc_m_i;
    logic [2:0]  funct3_m_i;
    logic [31:0] aluresult_m_i, readdata_m_i, pcplus4_m_i;
    logic [4:0]  a3_o, rd_w_o;
    logic [31:0] wd3_o, result_w_o;
    logic        we3_o, regwrite_w_o, misaligned_o;
    logic [63:0] instret_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: W validity and expected retired count.
    logic        m_valid = 1'b0;
    logic [63:0] exp_instret = 64'd0;

    always #5 clk = ~clk;

    ucsbece154b_writeback dut (
        .clk           (clk),
        .reset         (reset),
        .valid_m_i     (valid_m_i),
        .stall_w_i     (stall_w_i),
        .flush_w_i     (flush_w_i),
        .rd_m_i        (rd_m_i),
        .regwrite_m_i  (regwrite_m_i),
        .resultsrc_m_i (resultsrc_m_i),
        .funct3_m_i    (funct3_m_i),
        .aluresult_m_i (aluresult_m_i),
        .readdata_m_i  (readdata_m_i),
        .pcplus4_m_i   (pcplus4_m_i),
        .a3_o          (a3_o),
        .wd3_o         (wd3_o),
        .we3_o         (we3_o),
        .result_w_o    (result_w_o),
        .rd_w_o        (rd_w_o),
        .regwrite_w_o  (regwrite_w_o),
        .misaligned_o  (misaligned_o),
        .instret_o     (instret_o)
    );

    // Model of W validity and the retired counter, from the stated update rules.
    always @(posedge clk) begin
        if (reset) begin
            exp_instret = 64'd0;
        end else if (m_valid && !stall_w_i) begin
            exp_instret = exp_instret + 64'd1;
        end
        if (reset || flush_w_i) m_valid = 1'b0;
        else if (!stall_w_i)    m_valid = valid_m_i;
    end

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [4:0]  e_a3;
        logic [31:0] e_wd3;
        logic        e_we3;
        logic        e_mis;
        logic [4:0]  e_rdw;
    } vec_t;

    localparam int NVec = 17;
    vec_t vecs [NVec];

    function automatic vec_t mk(logic v, logic [4:0] rd, logic rw, logic [1:0] rs, logic [2:0] f3,
                                logic [31:0] alu, logic [31:0] rdata, logic [31:0] pc4,
                                logic [4:0] e_a3, logic [31:0] e_wd3, logic e_we3,
                                logic e_mis, logic [4:0] e_rdw);
        vec_t t;
        t.valid = v; t.rd = rd; t.rw = rw; t.rs = rs; t.f3 = f3;
        t.alu = alu; t.rdata = rdata; t.pc4 = pc4;
        t.e_a3 = e_a3; t.e_wd3 = e_wd3; t.e_we3 = e_we3; t.e_mis = e_mis; t.e_rdw = e_rdw;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4);
        valid_m_i = v; rd_m_i = rd; regwrite_m_i = rw; resultsrc_m_i = rs; funct3_m_i = f3;
        aluresult_m_i = alu; readdata_m_i = rdata; pcplus4_m_i = pc4;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " we3"}, 64'(we3_o), 64'd0);
        chk({tag, " regwrite_w"}, 64'(regwrite_w_o), 64'd0);
        chk({tag, " misaligned"}, 64'(misaligned_o), 64'd0);
        chk({tag, " a3"}, 64'(a3_o), 64'd0);
        chk({tag, " rd_w"}, 64'(rd_w_o), 64'd0);
        chk({tag, " wd3"}, 64'(wd3_o), 64'd0);
        chk({tag, " result_w"}, 64'(result_w_o), 64'd0);
        chk({tag, " instret"}, instret_o, 64'd0);
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        //           v  rd    rw  rs     f3      alu           rdata  pc4         a3    wd3           we3 mis rdw
        vecs[0]  = mk(1, 5'd5, 1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0,     5'd5, 32'h1234_5678, 1, 0, 5'd5);
        vecs[1]  = mk(1, 5'd6, 1, 2'b01, 3'b000, 32'h0000_1002, RD,    32'h0,     5'd6, 32'hFFFF_FFFF, 1, 0, 5'd6);
        vecs[2]  = mk(1, 5'd6, 1, 2'b01, 3'b100, 32'h0000_1002, RD,    32'h0,     5'd6, 32'h0000_00FF, 1, 0, 5'd6);
        vecs[3]  = mk(1, 5'd6, 1, 2'b01, 3'b001, 32'h0000_1002, RD,    32'h0,     5'd6, 32'hFFFF_80FF, 1, 0, 5'd6);
        vecs[4]  = mk(1, 5'd6, 1, 2'b01, 3'b101, 32'h0000_1002, RD,    32'h0,     5'd6, 32'h0000_80FF, 1, 0, 5'd6);
        vecs[5]  = mk(1, 5'd6, 1, 2'b01, 3'b000, 32'h0000_1001, RD,    32'h0,     5'd6, 32'h0000_007F, 1, 0, 5'd6);
        vecs[6]  = mk(1, 5'd6, 1, 2'b01, 3'b000, 32'h0000_1003, RD,    32'h0,     5'd6, 32'hFFFF_FF80, 1, 0, 5'd6);
        vecs[7]  = mk(1, 5'd6, 1, 2'b01, 3'b001, 32'h0000_1000, RD,    32'h0,     5'd6, 32'h0000_7F01, 1, 0, 5'd6);
        vecs[8]  = mk(1, 5'd6, 1, 2'b01, 3'b010, 32'h0000_1001, RD,    32'h0,     5'd6, RD,            0, 1, 5'd6);
        vecs[9]  = mk(1, 5'd6, 1, 2'b01, 3'b010, 32'h0000_1000, RD,    32'h0,     5'd6, RD,            1, 0, 5'd6);
        vecs[10] = mk(1, 5'd6, 1, 2'b01, 3'b001, 32'h0000_1001, RD,    32'h0,     5'd6, 32'h0000_7F01, 0, 1, 5'd6);
        vecs[11] = mk(1, 5'd1, 1, 2'b10, 3'b000, 32'hDEAD_0000, RD,    32'h104,   5'd1, 32'h0000_0104, 1, 0, 5'd1);
        vecs[12] = mk(1, 5'd2, 1, 2'b11, 3'b000, 32'hCAFE_F00D, RD,    32'h200,   5'd2, 32'hCAFE_F00D, 1, 0, 5'd2);
        vecs[13] = mk(1, 5'd0, 1, 2'b00, 3'b000, 32'h0000_00AA, RD,    32'h0,     5'd0, 32'h0000_00AA, 0, 0, 5'd0);
        vecs[14] = mk(1, 5'd7, 0, 2'b00, 3'b000, 32'h0000_00BB, RD,    32'h0,     5'd7, 32'h0000_00BB, 0, 0, 5'd7);
        vecs[15] = mk(0, 5'd9, 1, 2'b01, 3'b010, 32'h0000_1001, RD,    32'h0,     5'd9, RD,            0, 0, 5'd0);
        vecs[16] = mk(1, 5'd8, 1, 2'b01, 3'b011, 32'h0000_1001, RD,    32'h0,     5'd8, RD,            1, 0, 5'd8);

        reset = 1'b1; stall_w_i = 1'b0; flush_w_i = 1'b0;
        drive(1, 5'd31, 1, 2'b00, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cycle();
        cycle();
        chk_all_zero("reset");
        reset = 1'b0;

        // Table: each vector is captured at one edge and checked just after it.
        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].valid, vecs[i].rd, vecs[i].rw, vecs[i].rs, vecs[i].f3,
                  vecs[i].alu, vecs[i].rdata, vecs[i].pc4);
            cycle();
            chk($sformatf("v%0d a3", i), 64'(a3_o), 64'(vecs[i].e_a3));
            chk($sformatf("v%0d wd3", i), 64'(wd3_o), 64'(vecs[i].e_wd3));
            chk($sformatf("v%0d result_w", i), 64'(result_w_o), 64'(vecs[i].e_wd3));
            chk($sformatf("v%0d we3", i), 64'(we3_o), 64'(vecs[i].e_we3));
            chk($sformatf("v%0d regwrite_w", i), 64'(regwrite_w_o), 64'(vecs[i].e_we3));
            chk($sformatf("v%0d misaligned", i), 64'(misaligned_o), 64'(vecs[i].e_mis));
            chk($sformatf("v%0d rd_w", i), 64'(rd_w_o), 64'(vecs[i].e_rdw));
            chk($sformatf("v%0d instret", i), instret_o, exp_instret);
        end

        // First-retire latency: from a fresh reset, count goes 0 -> 1 one edge after W fills.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(1, 5'd5, 1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
        cycle();
        chk("first instret before", instret_o, 64'd0);
        drive(0, 5'd0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        cycle();
        chk("first instret after", instret_o, 64'd1);

        // JAL held by a 3-cycle stall: output stable, count advances once on release.
        drive(1, 5'd1, 1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h104);
        cycle();
        chk("jal instret enter", instret_o, 64'd1);
        stall_w_i = 1'b1;
        drive(1, 5'd3, 1, 2'b00, 3'b000, 32'h0000_0333, 32'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk($sformatf("stall%0d wd3", k), 64'(wd3_o), 64'h104);
            chk($sformatf("stall%0d a3", k), 64'(a3_o), 64'd1);
            chk($sformatf("stall%0d we3", k), 64'(we3_o), 64'd1);
            chk($sformatf("stall%0d instret", k), instret_o, 64'd1);
        end
        stall_w_i = 1'b0;
        cycle();
        chk("unstall wd3", 64'(wd3_o), 64'h333);
        chk("unstall instret", instret_o, 64'd2);

        // Flush with stall on a live W: slot is squashed, count does not advance.
        flush_w_i = 1'b1; stall_w_i = 1'b1;
        drive(1, 5'd4, 1, 2'b00, 3'b000, 32'h0000_0444, 32'h0, 32'h0);
        cycle();
        flush_w_i = 1'b0; stall_w_i = 1'b0;
        chk("flush we3", 64'(we3_o), 64'd0);
        chk("flush rd_w", 64'(rd_w_o), 64'd0);
        chk("flush instret", instret_o, 64'd2);
        chk("flush instret model", instret_o, exp_instret);

        // Counter wrap: preload all-ones while stalled, then retire one.
        drive(1, 5'd10, 1, 2'b00, 3'b000, 32'h0000_0AAA, 32'h0, 32'h0);
        cycle();
        stall_w_i = 1'b1;
        cycle();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("preload instret", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        stall_w_i = 1'b0;
        cycle();
        chk("wrap instret", instret_o, 64'd0);

        // Reset mid-stream with a live W and live M.
        drive(1, 5'd11, 1, 2'b00, 3'b000, 32'h0000_0BBB, 32'h0, 32'h0);
        cycle();
        chk("pre-reset we3", 64'(we3_o), 64'd1);
        reset = 1'b1;
        drive(1, 5'd12, 1, 2'b10, 3'b000, 32'h0000_0CCC, 32'h0, 32'h0000_0DDD);
        cycle();
        chk_all_zero("midreset");
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
